// File: rtl/slant_rx_deframer.sv
// slant_rx_deframer: recovers pixel-pair words from a 4-lane symbol stream framed by 24-symbol
// frame markers and 8-symbol line syncs. Optional error/frame statistics: define SLANT_RX_STATS_EN.
module slant_rx_deframer #(
    parameter logic [23:0] FRAME1     = 24'haab155,
    parameter logic [23:0] FRAME0     = 24'haa8d55,
    parameter logic [7:0]  HSYNC      = 8'h55,
    parameter int unsigned LINE_WORDS = 160,
    parameter int unsigned LINES      = 480
) (
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        RxValid,
    input  logic [5:0]  Rx0Data,
    input  logic [5:0]  Rx1Data,
    input  logic [5:0]  Rx2Data,
    input  logic [5:0]  Rx3Data,
    output logic        m_valid,
    output logic [19:0] m_ydata,
    output logic [19:0] m_cdata,
    output logic [8:0]  m_line,
    output logic [6:0]  m_word,
    output logic        FrameStart,
    output logic        FrameOdd,
    output logic        FrameDone,
    output logic        SyncErr,
    output logic [15:0] ErrCount,
    output logic [15:0] FrameCount
);

    localparam logic [7:0] LAST_SYM  = 8'(LINE_WORDS - 1);
    localparam logic [8:0] LAST_LINE = 9'(LINES - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_HSYNC = 2'd2
    } state_t;

    logic [5:0]  w_lane [4];
    logic [3:0]  w_lane_one;
    logic [3:0]  w_lane_zero;
    logic [3:0]  w_lane_hi;
    logic [19:0] w_value;
    logic        w_is_one;
    logic        w_is_zero;
    logic        w_is_bad;
    logic [23:0] w_one_hist_next;
    logic [23:0] w_ctl_hist_next;
    logic        w_mark1;
    logic        w_mark0;
    logic        w_hs_bit;
    logic        w_hs_ok;

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_one_hist;
    logic [23:0] r_ctl_hist;
    logic [7:0]  r_sym_cnt;
    logic [7:0]  w_sym_next;
    logic [2:0]  r_hs_idx;
    logic [2:0]  w_hs_next;
    logic [8:0]  r_line;
    logic [8:0]  w_line_next;
    logic        r_frame_odd;
    logic        w_odd_next;
    logic [19:0] r_y_hold;
    logic        r_m_valid;
    logic        r_frame_start;
    logic        r_frame_done;
    logic        r_sync_err;
    logic [19:0] r_m_ydata;
    logic [19:0] r_m_cdata;
    logic [6:0]  r_m_word;
    logic        w_start;
    logic        w_done;
    logic        w_err;
    logic        w_pair;
    logic        w_y_load;

    assign w_lane[0] = Rx0Data;
    assign w_lane[1] = Rx1Data;
    assign w_lane[2] = Rx2Data;
    assign w_lane[3] = Rx3Data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_one[gi]     = (w_lane[gi] == 6'h3f);
            assign w_lane_zero[gi]    = (w_lane[gi] == 6'h00);
            assign w_lane_hi[gi]      = w_lane[gi][5];
            assign w_value[5*gi +: 5] = w_lane[gi][4:0];
        end
    endgenerate

    // A ONE symbol has bit5 set on every lane, so it must be excluded from BAD explicitly.
    assign w_is_one  = &w_lane_one;
    assign w_is_zero = &w_lane_zero;
    assign w_is_bad  = (|w_lane_hi) && !w_is_one;

    assign w_one_hist_next = {r_one_hist[22:0], w_is_one};
    assign w_ctl_hist_next = {r_ctl_hist[22:0], w_is_one | w_is_zero};
    assign w_mark1 = RxValid && (&w_ctl_hist_next) && (w_one_hist_next == FRAME1);
    assign w_mark0 = RxValid && (&w_ctl_hist_next) && (w_one_hist_next == FRAME0);

    assign w_hs_bit = HSYNC[3'd7 - r_hs_idx];
    assign w_hs_ok  = w_hs_bit ? w_is_one : w_is_zero;

    always_comb begin
        w_state_next = r_state;
        w_sym_next   = r_sym_cnt;
        w_hs_next    = r_hs_idx;
        w_line_next  = r_line;
        w_odd_next   = r_frame_odd;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_pair       = 1'b0;
        w_y_load     = 1'b0;
        if (RxValid) begin
            if (w_mark1 || w_mark0) begin
                // A completed marker restarts the frame from any state.
                w_start      = 1'b1;
                w_odd_next   = w_mark1;
                w_line_next  = 9'd0;
                w_sym_next   = 8'd0;
                w_state_next = ST_DATA;
            end else begin
                case (r_state)
                    ST_DATA: begin
                        if (w_is_bad || w_is_one) begin
                            w_err        = 1'b1;
                            w_state_next = ST_HUNT;
                        end else begin
                            w_y_load = !r_sym_cnt[0];
                            w_pair   = r_sym_cnt[0];
                            if (r_sym_cnt == LAST_SYM) begin
                                w_sym_next = 8'd0;
                                if (r_line == LAST_LINE) begin
                                    w_done       = 1'b1;
                                    w_state_next = ST_HUNT;
                                end else begin
                                    w_hs_next    = 3'd0;
                                    w_state_next = ST_HSYNC;
                                end
                            end else begin
                                w_sym_next = r_sym_cnt + 8'd1;
                            end
                        end
                    end
                    ST_HSYNC: begin
                        if (!w_hs_ok) begin
                            w_err        = 1'b1;
                            w_state_next = ST_HUNT;
                        end else if (r_hs_idx == 3'd7) begin
                            w_line_next  = r_line + 9'd1;
                            w_sym_next   = 8'd0;
                            w_state_next = ST_DATA;
                        end else begin
                            w_hs_next = r_hs_idx + 3'd1;
                        end
                    end
                    default: begin
                        w_state_next = ST_HUNT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_HUNT;
            r_one_hist    <= 24'd0;
            r_ctl_hist    <= 24'd0;
            r_sym_cnt     <= 8'd0;
            r_hs_idx      <= 3'd0;
            r_line        <= 9'd0;
            r_frame_odd   <= 1'b0;
            r_y_hold      <= 20'd0;
            r_m_valid     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= 1'b0;
            r_m_ydata     <= 20'd0;
            r_m_cdata     <= 20'd0;
            r_m_word      <= 7'd0;
        end else begin
            r_state       <= w_state_next;
            r_sym_cnt     <= w_sym_next;
            r_hs_idx      <= w_hs_next;
            r_line        <= w_line_next;
            r_frame_odd   <= w_odd_next;
            r_m_valid     <= w_pair;
            r_frame_start <= w_start;
            r_frame_done  <= w_done;
            r_sync_err    <= w_err;
            if (RxValid) begin
                r_one_hist <= w_one_hist_next;
                r_ctl_hist <= w_ctl_hist_next;
            end
            if (w_y_load) begin
                r_y_hold <= w_value;
            end
            if (w_pair) begin
                r_m_ydata <= r_y_hold;
                r_m_cdata <= w_value;
                r_m_word  <= r_sym_cnt[7:1];
            end
        end
    end

    assign m_valid    = r_m_valid;
    assign m_ydata    = r_m_ydata;
    assign m_cdata    = r_m_cdata;
    assign m_line     = r_line;
    assign m_word     = r_m_word;
    assign FrameStart = r_frame_start;
    assign FrameOdd   = r_frame_odd;
    assign FrameDone  = r_frame_done;
    assign SyncErr    = r_sync_err;

`ifdef SLANT_RX_STATS_EN
    logic [15:0] r_err_count;
    logic [15:0] r_frame_count;

    // Saturating counters, visible in the same cycle as the pulse they count.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_err_count   <= 16'h0000;
            r_frame_count <= 16'h0000;
        end else begin
            if (w_err && (r_err_count != 16'hffff)) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_done && (r_frame_count != 16'hffff)) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign ErrCount   = r_err_count;
    assign FrameCount = r_frame_count;
`else
    assign ErrCount   = 16'h0000;
    assign FrameCount = 16'h0000;
`endif

endmodule

// File: tb/tb_slant_rx_deframer.sv
// tb_slant_rx_deframer: directed and randomized symbol streams checked cycle by cycle against a
// frame-position reference model (symbols since marker, line = pos / 168).
module tb_slant_rx_deframer;

    localparam int TB_LINES = 8;
    localparam int LW       = 160;
    localparam int PERIOD   = LW + 8;
    localparam int C_DATA   = 0;
    localparam int C_ONE    = 1;
    localparam int C_ZERO   = 2;
    localparam int C_BAD    = 3;

    logic        Cclk = 1'b0;
    logic        rstn = 1'b0;
    logic        RxValid = 1'b0;
    logic [5:0]  Rx0Data = 6'd0;
    logic [5:0]  Rx1Data = 6'd0;
    logic [5:0]  Rx2Data = 6'd0;
    logic [5:0]  Rx3Data = 6'd0;
    logic        m_valid;
    logic [19:0] m_ydata;
    logic [19:0] m_cdata;
    logic [8:0]  m_line;
    logic [6:0]  m_word;
    logic        FrameStart;
    logic        FrameOdd;
    logic        FrameDone;
    logic        SyncErr;
    logic [15:0] ErrCount;
    logic [15:0] FrameCount;

    slant_rx_deframer #(.LINES(TB_LINES)) dut (
        .Cclk(Cclk), .rstn(rstn), .RxValid(RxValid),
        .Rx0Data(Rx0Data), .Rx1Data(Rx1Data), .Rx2Data(Rx2Data), .Rx3Data(Rx3Data),
        .m_valid(m_valid), .m_ydata(m_ydata), .m_cdata(m_cdata), .m_line(m_line), .m_word(m_word),
        .FrameStart(FrameStart), .FrameOdd(FrameOdd), .FrameDone(FrameDone), .SyncErr(SyncErr),
        .ErrCount(ErrCount), .FrameCount(FrameCount)
    );

    always #5 Cclk = ~Cclk;

    int n_checks = 0;
    int n_errors = 0;
    bit stats_on;

    logic [23:0] mk1    = 24'haab155;
    logic [23:0] mk0    = 24'haa8d55;
    logic [7:0]  hs_pat = 8'h55;
    logic [23:0] ONES   = 24'hffffff;
    logic [23:0] YFIX   = {6'd4, 6'd3, 6'd2, 6'd1};
    logic [23:0] CFIX   = {4{6'h10}};
    logic [23:0] BADL2  = {6'd4, 6'h25, 6'd2, 6'd1};

    // reference model state
    int          hist[$];
    bit          hunting;
    int          pos;
    logic [19:0] y_hold;
    bit          e_valid, e_start, e_done, e_err, e_odd;
    logic [19:0] e_y, e_c;
    int          e_line, e_word, e_errcnt, e_frmcnt;

    // observed pulse tallies for scenario-level checks
    int obs_valid, obs_start, obs_done, obs_err, last_line, last_word;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [23:0] s);
        if (s == 24'hffffff) return C_ONE;
        if (s == 24'h000000) return C_ZERO;
        if (s[5] || s[11] || s[17] || s[23]) return C_BAD;
        return C_DATA;
    endfunction

    function automatic logic [19:0] sym_value(input logic [23:0] s);
        return {s[22:18], s[16:12], s[10:6], s[4:0]};
    endfunction

    function automatic bit marker_match(input logic [23:0] mk);
        if (hist.size() != 24) return 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (hist[i] != C_ONE && hist[i] != C_ZERO) return 1'b0;
            if ((hist[i] == C_ONE) != mk[23-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hunting  = 1'b1;
        pos      = 0;
        y_hold   = 20'd0;
        e_odd    = 1'b0;
        e_y      = 20'd0;
        e_c      = 20'd0;
        e_line   = 0;
        e_word   = 0;
        e_errcnt = 0;
        e_frmcnt = 0;
    endtask

    task automatic model_err();
        e_err   = 1'b1;
        hunting = 1'b1;
        if (stats_on && e_errcnt < 65535) e_errcnt++;
    endtask

    task automatic model_step(input logic [23:0] s);
        int k, off, ln, want;
        k = classify(s);
        hist.push_back(k);
        if (hist.size() > 24) void'(hist.pop_front());
        if (marker_match(mk1) || marker_match(mk0)) begin
            e_start = 1'b1;
            e_odd   = marker_match(mk1);
            hunting = 1'b0;
            pos     = 0;
            return;
        end
        if (hunting) return;
        off = pos % PERIOD;
        ln  = pos / PERIOD;
        if (off < LW) begin
            if (k == C_BAD || k == C_ONE) begin
                model_err();
            end else begin
                if (off % 2 == 0) begin
                    y_hold = sym_value(s);
                end else begin
                    e_valid = 1'b1;
                    e_y     = y_hold;
                    e_c     = sym_value(s);
                    e_line  = ln;
                    e_word  = off / 2;
                end
                if (off == LW - 1 && ln == TB_LINES - 1) begin
                    e_done  = 1'b1;
                    hunting = 1'b1;
                    if (stats_on && e_frmcnt < 65535) e_frmcnt++;
                end
                pos++;
            end
        end else begin
            want = hs_pat[7 - (off - LW)] ? C_ONE : C_ZERO;
            if (k != want) model_err();
            else pos++;
        end
    endtask

    task automatic check_zero(input string p);
        check_val({p, "_m_valid"},    32'(m_valid),    32'd0);
        check_val({p, "_m_ydata"},    32'(m_ydata),    32'd0);
        check_val({p, "_m_cdata"},    32'(m_cdata),    32'd0);
        check_val({p, "_m_line"},     32'(m_line),     32'd0);
        check_val({p, "_m_word"},     32'(m_word),     32'd0);
        check_val({p, "_FrameStart"}, 32'(FrameStart), 32'd0);
        check_val({p, "_FrameOdd"},   32'(FrameOdd),   32'd0);
        check_val({p, "_FrameDone"},  32'(FrameDone),  32'd0);
        check_val({p, "_SyncErr"},    32'(SyncErr),    32'd0);
        check_val({p, "_ErrCount"},   32'(ErrCount),   32'd0);
        check_val({p, "_FrameCount"}, 32'(FrameCount), 32'd0);
    endtask

    // One clock: drive at negedge, compare the registered response at the following negedge.
    task automatic tick(input bit v, input logic [23:0] s);
        logic [23:0] d;
        d = v ? s : 24'($urandom());
        RxValid = v;
        {Rx3Data, Rx2Data, Rx1Data, Rx0Data} = d;
        e_valid = 1'b0;
        e_start = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        if (v) model_step(s);
        @(posedge Cclk);
        @(negedge Cclk);
        check_val("m_valid",    32'(m_valid),    32'(e_valid));
        check_val("FrameStart", 32'(FrameStart), 32'(e_start));
        check_val("FrameDone",  32'(FrameDone),  32'(e_done));
        check_val("SyncErr",    32'(SyncErr),    32'(e_err));
        check_val("FrameOdd",   32'(FrameOdd),   32'(e_odd));
        check_val("ErrCount",   32'(ErrCount),   32'(e_errcnt));
        check_val("FrameCount", 32'(FrameCount), 32'(e_frmcnt));
        if (e_valid) begin
            check_val("m_ydata", 32'(m_ydata), 32'(e_y));
            check_val("m_cdata", 32'(m_cdata), 32'(e_c));
            check_val("m_line",  32'(m_line),  32'(e_line));
            check_val("m_word",  32'(m_word),  32'(e_word));
        end
        if (m_valid) begin
            obs_valid++;
            last_line = int'(m_line);
            last_word = int'(m_word);
        end
        if (FrameStart) obs_start++;
        if (FrameDone)  obs_done++;
        if (SyncErr)    obs_err++;
    endtask

    task automatic send(input logic [23:0] s);
        int gap;
        tick(1'b1, s);
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (gap) tick(1'b0, 24'h0);
    endtask

    task automatic send_marker(input logic [23:0] mk);
        for (int i = 23; i >= 0; i--) send(mk[i] ? ONES : 24'h0);
    endtask

    task automatic send_hsync(input logic [7:0] h);
        for (int i = 7; i >= 0; i--) send(h[i] ? ONES : 24'h0);
    endtask

    // mode 0: fixed Y/C pattern, 1: random data, 2: random data with sporadic corruption
    task automatic send_line(input int mode, input int nsym, input int bad_at, input logic [23:0] bad_sym);
        logic [23:0] s;
        int r;
        for (int w = 0; w < nsym; w++) begin
            if (mode == 0) s = (w % 2 == 0) ? YFIX : CFIX;
            else s = 24'($urandom()) & 24'h7df7df;
            if (mode == 2) begin
                r = int'($urandom_range(0, 999));
                if (r < 2) s = s | (24'h20 << (6 * $urandom_range(0, 3)));
                else if (r < 3) s = ONES;
                else if (r < 6) s = 24'h0;
            end
            if (w == bad_at) s = bad_sym;
            send(s);
        end
    endtask

    task automatic clr_obs();
        obs_valid = 0;
        obs_start = 0;
        obs_done  = 0;
        obs_err   = 0;
        last_line = -1;
        last_word = -1;
    endtask

    task automatic do_reset(input string p);
        RxValid = 1'b0;
        #2 rstn = 1'b0;
        #1 check_zero(p);
        model_reset();
        @(negedge Cclk);
        @(negedge Cclk);
        rstn = 1'b1;
        clr_obs();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] hs_bad;
`ifdef SLANT_RX_STATS_EN
        stats_on = 1'b1;
`else
        stats_on = 1'b0;
`endif
        model_reset();
        clr_obs();
        rstn = 1'b0;
        @(negedge Cclk);
        check_zero("reset");
        @(negedge Cclk);
        rstn = 1'b1;
        repeat (3) tick(1'b0, 24'h0);

        // full FRAME1 frame with fixed pattern
        send_marker(mk1);
        for (int ln = 0; ln < TB_LINES; ln++) begin
            send_line(0, LW, -1, 24'h0);
            if (ln < TB_LINES - 1) send_hsync(hs_pat);
        end
        repeat (2) tick(1'b0, 24'h0);
        check_val("full_valid_cnt", 32'(obs_valid), 32'(TB_LINES * 80));
        check_val("full_start_cnt", 32'(obs_start), 32'd1);
        check_val("full_done_cnt",  32'(obs_done),  32'd1);
        check_val("full_err_cnt",   32'(obs_err),   32'd0);
        check_val("full_last_line", 32'(last_line), 32'(TB_LINES - 1));
        check_val("full_last_word", 32'(last_word), 32'd79);
        check_val("full_odd",       32'(FrameOdd),  32'd1);
        check_val("full_frmcount",  32'(FrameCount), stats_on ? 32'd1 : 32'd0);
        $display("[%0t] full frame: %0d pairs, %0d done", $time, obs_valid, obs_done);

        // FRAME0 then one line
        do_reset("r1");
        send_marker(mk0);
        send_line(1, LW, -1, 24'h0);
        repeat (2) tick(1'b0, 24'h0);
        check_val("f0_odd",       32'(FrameOdd),  32'd0);
        check_val("f0_valid_cnt", 32'(obs_valid), 32'd80);
        check_val("f0_start_cnt", 32'(obs_start), 32'd1);
        $display("[%0t] frame0 line: %0d pairs", $time, obs_valid);

        // corrupted line sync after line 3
        do_reset("r2");
        send_marker(mk1);
        for (int ln = 0; ln < 4; ln++) begin
            send_line(1, LW, -1, 24'h0);
            send_hsync(ln == 3 ? 8'h75 : hs_pat);
        end
        send_line(1, LW, -1, 24'h0);
        repeat (2) tick(1'b0, 24'h0);
        check_val("hs_err_cnt",   32'(obs_err),   32'd1);
        check_val("hs_valid_cnt", 32'(obs_valid), 32'd320);
        check_val("hs_errcount",  32'(ErrCount),  stats_on ? 32'd1 : 32'd0);
        $display("[%0t] hsync error: %0d errors, %0d pairs", $time, obs_err, obs_valid);

        // bad lane 2 symbol mid-line
        do_reset("r3");
        send_marker(mk1);
        send_line(0, LW, -1, 24'h0);
        send_hsync(hs_pat);
        send_line(0, LW, 77, BADL2);
        repeat (2) tick(1'b0, 24'h0);
        check_val("bad_err_cnt",   32'(obs_err),   32'd1);
        check_val("bad_valid_cnt", 32'(obs_valid), 32'd118);
        $display("[%0t] bad lane: %0d errors, %0d pairs", $time, obs_err, obs_valid);

        // new marker in the middle of a line restarts the frame
        do_reset("r4");
        send_marker(mk0);
        for (int ln = 0; ln < 5; ln++) begin
            send_line(1, LW, -1, 24'h0);
            send_hsync(hs_pat);
        end
        send_line(1, 50, -1, 24'h0);
        send_marker(mk1);
        clr_obs();
        send_line(0, LW, -1, 24'h0);
        repeat (2) tick(1'b0, 24'h0);
        check_val("restart_start_cnt", 32'(obs_start), 32'd0);
        check_val("restart_valid_cnt", 32'(obs_valid), 32'd80);
        check_val("restart_line",      32'(last_line), 32'd0);
        check_val("restart_odd",       32'(FrameOdd),  32'd1);
        $display("[%0t] mid-line marker: %0d pairs after restart", $time, obs_valid);

        // asynchronous reset at pair 40 of line 2
        do_reset("r5");
        send_marker(mk1);
        for (int ln = 0; ln < 2; ln++) begin
            send_line(0, LW, -1, 24'h0);
            send_hsync(hs_pat);
        end
        send_line(0, 81, -1, 24'h0);
        do_reset("midrst");
        send_line(1, 79, -1, 24'h0);
        send_hsync(hs_pat);
        send_line(1, LW, -1, 24'h0);
        check_val("postrst_valid_cnt", 32'(obs_valid), 32'd0);
        send_marker(mk0);
        send_line(1, LW, -1, 24'h0);
        repeat (2) tick(1'b0, 24'h0);
        check_val("resume_valid_cnt", 32'(obs_valid), 32'd80);
        $display("[%0t] mid-frame reset: %0d pairs after new marker", $time, obs_valid);

        // randomized frames with sporadic corruption
        do_reset("r6");
        for (int f = 0; f < 3; f++) begin
            int npre;
            npre = int'($urandom_range(0, 30));
            for (int i = 0; i < npre; i++) begin
                case ($urandom_range(0, 2))
                    0: send(ONES);
                    1: send(24'h0);
                    default: send(24'($urandom()) & 24'h7df7df);
                endcase
            end
            send_marker($urandom_range(0, 1) ? mk1 : mk0);
            for (int ln = 0; ln < TB_LINES; ln++) begin
                send_line(2, LW, -1, 24'h0);
                if (ln < TB_LINES - 1) begin
                    hs_bad = hs_pat;
                    if ($urandom_range(0, 7) == 0) hs_bad[$urandom_range(0, 7)] ^= 1'b1;
                    send_hsync(hs_bad);
                end
            end
            repeat (2) tick(1'b0, 24'h0);
            $display("[%0t] random frame %0d: %0d pairs, %0d errors, %0d done", $time, f, obs_valid, obs_err, obs_done);
            clr_obs();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
